// File: rtl/yolo_conv_top_mac_pipe.sv
// Pipelined multiply-accumulate: NUM_STAGE product registers feed a grouped accumulator
// with optional saturation and a sticky overflow flag reported per group.
module yolo_conv_top_mac_pipe #(
    parameter int unsigned A_WIDTH   = 6,
    parameter int unsigned A_SIGNED  = 0,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned P_WIDTH   = 22,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned NUM_STAGE = 2,
    parameter int unsigned SAT       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 acc_valid,
    output logic [ACC_WIDTH-1:0] acc_dout,
    output logic                 acc_ovf
);

    localparam int unsigned FULL_W = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned TOP    = NUM_STAGE - 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [A_WIDTH:0]   a_ext;
    logic signed [B_WIDTH-1:0] b_s;
    logic signed [P_WIDTH-1:0] prod_p;

    logic [NUM_STAGE-1:0] vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
    logic [NUM_STAGE-1:0][P_WIDTH-1:0] prod_q, prod_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [ACC_WIDTH-1:0] dout_q, dout_d;
    logic                 ovfo_q, ovfo_d;

    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        ovf_now;
    logic                        sticky;
    logic [ACC_WIDTH-1:0]        res;

    // Only the low P_WIDTH bits of the full-width product are kept.
    always_comb begin
        a_ext  = (A_SIGNED != 0) ? {din0[A_WIDTH-1], din0} : {1'b0, din0};
        b_s    = din1;
        prod_p = P_WIDTH'(FULL_W'(a_ext) * FULL_W'(b_s));
    end

    always_comb begin
        vld_d     = vld_q;
        fst_d     = fst_q;
        lst_d     = lst_q;
        prod_d    = prod_q;
        vld_d[0]  = in_valid;
        fst_d[0]  = in_valid & in_first;
        lst_d[0]  = in_valid & in_last;
        prod_d[0] = prod_p;
        for (int i = 1; i < NUM_STAGE; i++) begin
            vld_d[i]  = vld_q[i-1];
            fst_d[i]  = fst_q[i-1];
            lst_d[i]  = lst_q[i-1];
            prod_d[i] = prod_q[i-1];
        end
    end

    // Sum is one bit wider so overflow shows up as a mismatch of the top two bits.
    always_comb begin
        p_ext   = ACC_WIDTH'($signed(prod_q[TOP]));
        base    = fst_q[TOP] ? '0 : acc_q;
        sum     = (ACC_WIDTH+1)'(p_ext) + (ACC_WIDTH+1)'(base);
        ovf_now = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        if (ovf_now && (SAT != 0)) begin
            res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            res = sum[ACC_WIDTH-1:0];
        end
        sticky = (fst_q[TOP] ? 1'b0 : ovf_q) | ovf_now;
    end

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        dout_d  = dout_q;
        ovfo_d  = ovfo_q;
        if (vld_q[TOP]) begin
            ovf_d = sticky;
            acc_d = lst_q[TOP] ? '0 : res;
            if (lst_q[TOP]) begin
                valid_d = 1'b1;
                dout_d  = res;
                ovfo_d  = sticky;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            fst_q   <= '0;
            lst_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            ovfo_q  <= 1'b0;
        end else if (ce) begin
            vld_q   <= vld_d;
            fst_q   <= fst_d;
            lst_q   <= lst_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            ovfo_q  <= ovfo_d;
        end
    end

    assign acc_valid = valid_q;
    assign acc_dout  = dout_q;
    assign acc_ovf   = ovfo_q;

endmodule

// File: tb/tb_yolo_conv_top_mac_pipe.sv
// Drives one beat stream into four differently parametrised MAC instances and scoreboards
// each instance's group results against an arithmetic reference model.
module tb_yolo_conv_top_mac_pipe;

    typedef struct {
        int     k;
        longint val;
        bit     ovf;
        int     due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_first, in_last;
    logic [5:0]  din0;
    logic [15:0] din1;

    logic        v0, v1, v2, v3, o0, o1, o2, o3;
    logic [31:0] d0;
    logic [21:0] d1, d2;
    logic [11:0] d3;

    int     n_total = 0;
    int     n_pass  = 0;
    int     en_cnt  = 0;
    exp_t   sb[$];
    longint m_acc[4];
    bit     m_ovf[4];

    always #5 clk = ~clk;

    yolo_conv_top_mac_pipe #(.A_WIDTH(6), .A_SIGNED(0), .B_WIDTH(16), .P_WIDTH(22),
        .ACC_WIDTH(32), .NUM_STAGE(2), .SAT(1)) u_dut0 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .acc_valid(v0), .acc_dout(d0), .acc_ovf(o0));
    yolo_conv_top_mac_pipe #(.A_WIDTH(6), .A_SIGNED(0), .B_WIDTH(16), .P_WIDTH(22),
        .ACC_WIDTH(22), .NUM_STAGE(2), .SAT(1)) u_dut1 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .acc_valid(v1), .acc_dout(d1), .acc_ovf(o1));
    yolo_conv_top_mac_pipe #(.A_WIDTH(6), .A_SIGNED(0), .B_WIDTH(16), .P_WIDTH(22),
        .ACC_WIDTH(22), .NUM_STAGE(3), .SAT(0)) u_dut2 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .acc_valid(v2), .acc_dout(d2), .acc_ovf(o2));
    yolo_conv_top_mac_pipe #(.A_WIDTH(6), .A_SIGNED(1), .B_WIDTH(16), .P_WIDTH(8),
        .ACC_WIDTH(12), .NUM_STAGE(1), .SAT(1)) u_dut3 (.clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .acc_valid(v3), .acc_dout(d3), .acc_ovf(o3));

    function automatic void get_cfg(input int k, output int a_s, output int pw, output int aw,
                                    output int sat, output int ns);
        case (k)
            0:       begin a_s = 0; pw = 22; aw = 32; sat = 1; ns = 2; end
            1:       begin a_s = 0; pw = 22; aw = 22; sat = 1; ns = 2; end
            2:       begin a_s = 0; pw = 22; aw = 22; sat = 0; ns = 3; end
            default: begin a_s = 1; pw = 8;  aw = 12; sat = 1; ns = 1; end
        endcase
    endfunction

    task automatic check(input string name, input int k, input bit ok, input longint act,
                         input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    endtask

    // Reference: integer product, wrap into P bits, then add with clamp or modular wrap.
    function automatic void model(input int k, input int a_raw, input int b_raw, input bit f,
                                  input bit l, input int edge_no);
        int a_s, pw, aw, sat, ns;
        longint a, b, p, s, mx, mn, one;
        bit ov;
        exp_t e;
        get_cfg(k, a_s, pw, aw, sat, ns);
        one = 1;
        a = (a_s != 0 && a_raw >= 32) ? a_raw - 64 : a_raw;
        b = (b_raw >= 32768) ? b_raw - 65536 : b_raw;
        p = (a * b) & ((one << pw) - 1);
        if (p >= (one << (pw - 1))) p = p - (one << pw);
        s  = (f ? 0 : m_acc[k]) + p;
        ov = f ? 1'b0 : m_ovf[k];
        mx = (one << (aw - 1)) - 1;
        mn = -(one << (aw - 1));
        if (s > mx) begin
            ov = 1'b1;
            s  = (sat != 0) ? mx : s - (one << aw);
        end else if (s < mn) begin
            ov = 1'b1;
            s  = (sat != 0) ? mn : s + (one << aw);
        end
        m_ovf[k] = ov;
        if (l) begin
            e.k = k; e.val = s; e.ovf = ov; e.due = edge_no + ns;
            sb.push_back(e);
            m_acc[k] = 0;
        end else begin
            m_acc[k] = s;
        end
    endfunction

    task automatic chk_out(input int k, input bit v, input longint d, input bit o);
        int idx;
        exp_t e;
        if (!v) return;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].k == k) idx = i;
        end
        if (idx < 0) begin
            check("spurious_valid", k, 1'b0, 1, 0);
            return;
        end
        e = sb[idx];
        sb.delete(idx);
        check("acc_dout", k, d == e.val, d, e.val);
        check("acc_ovf", k, o == e.ovf, longint'(o), longint'(e.ovf));
        check("latency", k, en_cnt == e.due, en_cnt, e.due);
    endtask

    always @(posedge clk) if (!reset && ce) en_cnt <= en_cnt + 1;

    // Valid only counts in enabled cycles; a held valid during ce=0 must not double-count.
    always @(negedge clk) begin
        if (!reset && ce) begin
            chk_out(0, v0, longint'($signed(d0)), o0);
            chk_out(1, v1, longint'($signed(d1)), o1);
            chk_out(2, v2, longint'($signed(d2)), o2);
            chk_out(3, v3, longint'($signed(d3)), o3);
        end
    end

    task automatic cyc(input bit v, input bit f, input bit l, input int a, input int b,
                       input bit c);
        in_valid = v; in_first = f; in_last = l;
        din0 = 6'(a); din1 = 16'(b); ce = c;
        if (v && c) begin
            for (int k = 0; k < 4; k++) model(k, a & 63, b & 65535, f, l, en_cnt + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        idle(4);
        check("drain_pending", 0, sb.size() == 0, sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_zero();
        check("rst_valid", 0, v0 == 0, v0, 0);
        check("rst_dout", 0, d0 == 0, d0, 0);
        check("rst_ovf", 0, o0 == 0, o0, 0);
        check("rst_valid", 1, v1 == 0, v1, 0);
        check("rst_dout", 1, d1 == 0, d1, 0);
        check("rst_ovf", 1, o1 == 0, o1, 0);
        check("rst_valid", 2, v2 == 0, v2, 0);
        check("rst_dout", 2, d2 == 0, d2, 0);
        check("rst_ovf", 2, o2 == 0, o2, 0);
        check("rst_valid", 3, v3 == 0, v3, 0);
        check("rst_dout", 3, d3 == 0, d3, 0);
        check("rst_ovf", 3, o3 == 0, o3, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; ce = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 4; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        chk_zero();
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        din0 = '0; din1 = '0;
        for (int k = 0; k < 4; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero();

        // Single full-scale beat.
        cyc(1, 1, 1, 63, -32768, 1);
        drain();

        // Four-beat group followed immediately by a one-beat group.
        cyc(1, 1, 0, 10, 100, 1);
        cyc(1, 0, 0, 20, -50, 1);
        cyc(1, 0, 0, 1, 1, 1);
        cyc(1, 0, 1, 63, -1, 1);
        cyc(1, 1, 1, 2, 3, 1);
        drain();

        // Saturation / wrap, then recovery with a fresh group.
        cyc(1, 1, 0, 63, 32767, 1);
        cyc(1, 0, 1, 63, 32767, 1);
        cyc(1, 1, 1, 1, 1, 1);
        drain();

        // Signed-A truncation case.
        cyc(1, 1, 1, -32, 5, 1);
        drain();

        // Stall right after the last beat, then a stall while the result is showing.
        cyc(1, 1, 0, 1, 1, 1);
        cyc(1, 0, 0, 1, 1, 1);
        cyc(1, 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        drain();

        // Reset with a partial group in flight.
        cyc(1, 1, 0, 5, 5, 1);
        cyc(1, 0, 0, 5, 5, 1);
        do_reset();
        cyc(1, 1, 1, 1, 7, 1);
        drain();

        // Random groups with bubbles, ce stalls and ignored framing on invalid beats.
        for (int g = 0; g < 60; g++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        cyc(0, 1'($urandom), 1'($urandom), $urandom, $urandom, 1);
                    else
                        cyc(1, 1'($urandom), 1'($urandom), $urandom, $urandom, 0);
                end
                cyc(1, (i == 0) && ($urandom_range(0, 9) != 0), i == len - 1,
                    $urandom_range(0, 63), $urandom_range(0, 65535), 1);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/yolo_conv_top_mac_pipe.md
Name: yolo_conv_top_mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit; successor to the single-cycle 6ns×16s→22 DSP48 multiplier wrappers in yolo_conv_top.
- Generalises operand widths, operand signedness and multiplier pipeline depth.
- Adds grouped accumulation (first/last framing), an optional saturating accumulator and a sticky overflow flag.
- Sits between the weight/feature-map buffers and the conv output stage; reduces one kernel window (N products) to one partial sum.

Parameters:
- A_WIDTH, 6: width of din0.
- A_SIGNED, 0: 0 = din0 unsigned (zero-extended), 1 = signed.
- B_WIDTH, 16: width of din1; always signed.
- P_WIDTH, 22: product width after truncation; must be ≤ A_WIDTH+B_WIDTH+1.
- ACC_WIDTH, 32: accumulator/output width; must be ≥ P_WIDTH.
- NUM_STAGE, 2: multiplier pipeline registers; must be ≥ 1.
- SAT, 1: 1 = saturate accumulator, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every register, including valids and outputs.
- in_valid  in  1  beat valid.
- in_first  in  1  beat starts a new group; qualified by in_valid.
- in_last  in  1  beat ends the group; qualified by in_valid.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B, signed.
- acc_valid  out  1  group result valid.
- acc_dout  out  ACC_WIDTH  signed group sum.
- acc_ovf  out  1  saturation/wrap occurred in this group.

Behaviour:
- Reset (reset=1 at a rising edge, regardless of ce) clears:
  - all pipeline valid bits and data registers, and the accumulator;
  - acc_valid=0, acc_dout=0, acc_ovf=0, sticky ovf=0.
- Reset mid-group discards the partial group and all in-flight beats; no result is emitted for them.
- Product:
  - A is extended to A_WIDTH+1 bits (zero-extended if A_SIGNED=0, sign-extended if 1).
  - Signed product is A×B at full width A_WIDTH+B_WIDTH+1.
  - The product is truncated to its low P_WIDTH bits as a signed value.
  - The product is sign-extended to ACC_WIDTH before accumulation.
- Pipeline:
  - NUM_STAGE product registers, each carrying valid, first and last, then one accumulator register.
  - With ce held at 1, a beat sampled at the end of cycle c contributes at the end of cycle c+NUM_STAGE.
  - For a last beat, acc_valid is high during cycle c+NUM_STAGE+1.
  - ce=0 cycles add exactly one cycle each. There is no internal back-pressure: one beat can be accepted every enabled cycle.
- Accumulate (on an enabled edge where the final stage is valid):
  - If first: acc = p.
  - Else: acc = acc + p.
  - After a last beat is absorbed, the internal acc returns to 0. A following beat without first therefore starts from 0.
  - first and last on the same beat: result = p.
- Overflow (SAT=1):
  - Sum computed at ACC_WIDTH+1 bits.
  - Clamped to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) when out of range.
- Overflow (SAT=0): sum wraps modulo 2^ACC_WIDTH.
- Overflow flag:
  - Either SAT mode sets a sticky ovf on overflow.
  - Sticky ovf is cleared by a first beat; a first beat cannot itself overflow.
- Outputs:
  - acc_valid is registered and high for exactly one enabled cycle per last beat. While ce=0 it holds its value; consumers qualify it with ce.
  - acc_dout and acc_ovf update only when acc_valid is set and hold between results.
- in_first/in_last with in_valid=0 are ignored; bubbles inside a group are allowed.

Test Plan:
- Single beat (defaults): din0=63, din1=-32768, first=last=1 at cycle 0 → acc_valid=1 only in cycle 3, acc_dout=-2064384, acc_ovf=0.
- Four-beat group on back-to-back cycles: (10,100), (20,-50), (1,1), (63,-1) → one acc_valid, 3 cycles after the last beat, acc_dout=-62. Immediately follow with a 1-beat group (2,3) → next cycle acc_dout=6.
- Saturation (ACC_WIDTH=22, SAT=1): two beats (63,32767) → acc_dout=2097151, acc_ovf=1. Next group single (1,1) → acc_dout=1, acc_ovf=0. With SAT=0, the same two beats → acc_dout=4128642-4194304=-65662, acc_ovf=1.
- Signedness/truncation (A_SIGNED=1, A_WIDTH=6, P_WIDTH=8): din0=-32, din1=5 → full product -160, truncated to 8 bits = 96 → acc_dout=96.
- Stall: 3-beat group (1,1)×3 with ce=0 for 2 cycles mid-pipeline → acc_dout=3 appears 2 cycles later than unstalled; acc_valid stays high during a stall and counts once; no beat lost or duplicated.
- Reset mid-group: beats (5,5), (5,5), reset=1 for one cycle, then a group (1,7) first/last → no result for the aborted beats, exactly one acc_valid with acc_dout=7. All outputs are 0 in the cycle after reset.
